// File: rtl/ulap_pkg.sv
// ---------------------------------------------------------------------------
// | ulap_pkg : shared constants and state types for the ULAplus loader      |
// | Build option: ULAP_LOADER_READBACK_EN adds the RD_CHK state             |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

package ulap_pkg;

  localparam logic [15:0] ULAP_SEL_PORT  = 16'hBF3B;
  localparam logic [15:0] ULAP_DATA_PORT = 16'hFF3B;
  localparam logic [7:0]  ULAP_GRP_MODE  = 8'h40;
  localparam int          ULAP_PAL_SIZE  = 64;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_BUSREQ,
    ST_FETCH,
    ST_WR_SEL,
    ST_WR_DATA,
`ifdef ULAP_LOADER_READBACK_EN
    ST_RD_CHK,
`endif
    ST_FETCH_MODE,
    ST_WR_GRP,
    ST_WR_MODE,
    ST_FINISH
  } ulap_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_RECOV
  } ulap_phase_t;

endpackage

`default_nettype wire

// File: rtl/ulap_io_cycle.sv
// ---------------------------------------------------------------------------
// | ulap_io_cycle : one Z80-style IO cycle, SETUP / STROBE / RECOV          |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module ulap_io_cycle
  import ulap_pkg::*;
#(
  parameter int STROBE_CLKS = 3,
  parameter int RECOV_CLKS  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        go,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        is_read,
  input  logic [7:0]  io_din,
  output logic [15:0] io_addr,
  output logic [7:0]  io_dout,
  output logic        io_nIORQ,
  output logic        io_nWR,
  output logic        io_nRD,
  output logic [7:0]  rdata,
  output logic        ack
);

  localparam logic [3:0] c_strobe_last = 4'(STROBE_CLKS - 1);
  localparam logic [3:0] c_recov_last  = 4'(RECOV_CLKS - 1);

  ulap_phase_t r_phase, w_phase_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  logic [7:0]  r_rdata;
  logic        r_is_read;
  logic        r_nIORQ, r_nWR, r_nRD;
  logic        w_ack;
  logic        w_accept;

  // A new request is taken while idle or on the final RECOV clock, so
  // consecutive cycles run with no dead clock between them.
  assign w_ack    = (r_phase == PH_RECOV) && (r_cnt == 4'd0);
  assign w_accept = go && ((r_phase == PH_IDLE) || w_ack);

  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    case (r_phase)
      PH_IDLE: begin
        if (go) w_phase_nxt = PH_SETUP;
      end
      PH_SETUP: begin
        w_phase_nxt = PH_STROBE;
        w_cnt_nxt   = c_strobe_last;
      end
      PH_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_phase_nxt = PH_RECOV;
          w_cnt_nxt   = c_recov_last;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      PH_RECOV: begin
        if (r_cnt == 4'd0) begin
          w_phase_nxt = go ? PH_SETUP : PH_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: w_phase_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_phase   <= PH_IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= 16'h0000;
      r_data    <= 8'h00;
      r_is_read <= 1'b0;
      r_rdata   <= 8'h00;
      r_nIORQ   <= 1'b1;
      r_nWR     <= 1'b1;
      r_nRD     <= 1'b1;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr    <= addr;
        r_data    <= data;
        r_is_read <= is_read;
      end else if (w_phase_nxt == PH_IDLE) begin
        r_addr    <= 16'h0000;
        r_data    <= 8'h00;
        r_is_read <= 1'b0;
      end
      if ((r_phase == PH_STROBE) && (r_cnt == 4'd0)) r_rdata <= io_din;
      // Strobes are registered from the next phase so they change cleanly on the edge.
      r_nIORQ <= !(w_phase_nxt == PH_STROBE);
      r_nWR   <= !((w_phase_nxt == PH_STROBE) && !r_is_read);
      r_nRD   <= !((w_phase_nxt == PH_STROBE) && r_is_read);
    end
  end

  assign io_addr  = r_addr;
  assign io_dout  = r_data;
  assign io_nIORQ = r_nIORQ;
  assign io_nWR   = r_nWR;
  assign io_nRD   = r_nRD;
  assign rdata    = r_rdata;
  assign ack      = w_ack;

endmodule

`default_nettype wire

// File: rtl/ulap_loader.sv
// ---------------------------------------------------------------------------
// | ulap_loader : bus-mastering ULAplus palette/mode loader                 |
// | Build option: ULAP_LOADER_READBACK_EN verifies each palette write       |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module ulap_loader
  import ulap_pkg::*;
#(
  parameter int STROBE_CLKS = 3,
  parameter int RECOV_CLKS  = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] io_addr,
  output logic [7:0]  io_dout,
  output logic        io_nIORQ,
  output logic        io_nWR,
  output logic        io_nRD,
  input  logic [7:0]  io_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  ulap_state_t r_state, w_state_nxt;
  logic [5:0]  r_idx;
  logic [7:0]  r_byte;
  logic [1:0]  r_mode;
  logic        r_busy, r_done, r_busrq_n, r_s_ready;
  logic        w_go, w_is_read, w_idx_inc, w_byte_ld, w_mode_ld, w_err_set;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic        w_ack;
  logic [7:0]  w_rdata;
  logic        w_cyc_nrd;
  logic        w_last_idx;
  logic        w_start_ok;

  assign w_last_idx = (r_idx == 6'(ULAP_PAL_SIZE - 1));
  assign w_start_ok = (r_state == ST_IDLE) && start;

  ulap_io_cycle #(
    .STROBE_CLKS (STROBE_CLKS),
    .RECOV_CLKS  (RECOV_CLKS)
  ) u_io_cycle (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .go       (w_go),
    .addr     (w_addr),
    .data     (w_data),
    .is_read  (w_is_read),
    .io_din   (io_din),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_nIORQ (io_nIORQ),
    .io_nWR   (io_nWR),
    .io_nRD   (w_cyc_nrd),
    .rdata    (w_rdata),
    .ack      (w_ack)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // IO requests are issued on the transition into a write/read state so the
  // cycle's SETUP clock coincides with the first clock of that state.
  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_is_read   = 1'b0;
    w_addr      = ULAP_SEL_PORT;
    w_data      = 8'h00;
    w_idx_inc   = 1'b0;
    w_byte_ld   = 1'b0;
    w_mode_ld   = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_BUSREQ;
      end
      ST_BUSREQ: begin
        if (!busak_n) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (s_valid) begin
          w_byte_ld   = 1'b1;
          w_state_nxt = ST_WR_SEL;
          w_go        = 1'b1;
          w_addr      = ULAP_SEL_PORT;
          w_data      = {2'b00, r_idx};
        end
      end
      ST_WR_SEL: begin
        if (w_ack) begin
          w_state_nxt = ST_WR_DATA;
          w_go        = 1'b1;
          w_addr      = ULAP_DATA_PORT;
          w_data      = r_byte;
        end
      end
      ST_WR_DATA: begin
        if (w_ack) begin
`ifdef ULAP_LOADER_READBACK_EN
          w_state_nxt = ST_RD_CHK;
          w_go        = 1'b1;
          w_is_read   = 1'b1;
          w_addr      = ULAP_DATA_PORT;
`else
          w_idx_inc   = 1'b1;
          w_state_nxt = w_last_idx ? ST_FETCH_MODE : ST_FETCH;
`endif
        end
      end
`ifdef ULAP_LOADER_READBACK_EN
      ST_RD_CHK: begin
        if (w_ack) begin
          w_err_set   = (w_rdata != r_byte);
          w_idx_inc   = 1'b1;
          w_state_nxt = w_last_idx ? ST_FETCH_MODE : ST_FETCH;
        end
      end
`endif
      ST_FETCH_MODE: begin
        if (s_valid) begin
          w_mode_ld   = 1'b1;
          w_state_nxt = ST_WR_GRP;
          w_go        = 1'b1;
          w_addr      = ULAP_SEL_PORT;
          w_data      = ULAP_GRP_MODE;
        end
      end
      ST_WR_GRP: begin
        if (w_ack) begin
          w_state_nxt = ST_WR_MODE;
          w_go        = 1'b1;
          w_addr      = ULAP_DATA_PORT;
          w_data      = {6'b000000, r_mode};
        end
      end
      ST_WR_MODE: begin
        if (w_ack) w_state_nxt = ST_FINISH;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_idx     <= 6'd0;
      r_byte    <= 8'h00;
      r_mode    <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_busrq_n <= 1'b1;
      r_s_ready <= 1'b0;
    end else begin
      if (w_byte_ld) r_byte <= s_data;
      if (w_mode_ld) r_mode <= s_data[1:0];
      if (w_start_ok)     r_idx <= 6'd0;
      else if (w_idx_inc) r_idx <= r_idx + 6'd1;
      r_busy    <= (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_FINISH);
      r_done    <= (w_state_nxt == ST_FINISH);
      r_busrq_n <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FINISH);
      r_s_ready <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_FETCH_MODE);
    end
  end

`ifdef ULAP_LOADER_READBACK_EN
  logic r_err;

  always_ff @(posedge clk_sys) begin
    if (reset)          r_err <= 1'b0;
    else if (w_start_ok) r_err <= 1'b0;
    else if (w_err_set)  r_err <= 1'b1;
  end

  assign err   = r_err;
  assign io_nRD = w_cyc_nrd;
`else
  logic w_unused_rb;
  assign w_unused_rb = &{1'b0, w_rdata, w_cyc_nrd, w_err_set};
  assign err    = 1'b0;
  assign io_nRD = 1'b1;
`endif

  assign s_ready = r_s_ready;
  assign busrq_n = r_busrq_n;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_ulap_loader.sv
// ---------------------------------------------------------------------------
// | tb_ulap_loader : directed self-checking bench for ulap_loader           |
// | Honours ULAP_LOADER_READBACK_EN when defined for the build              |
// | Revision: 1.0                                                           |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ulap_loader;

  localparam int STROBE_CLKS = 3;
  localparam int RECOV_CLKS  = 2;
`ifdef ULAP_LOADER_READBACK_EN
  localparam int EXP_CLKS = 130 * (1 + STROBE_CLKS + RECOV_CLKS) + 64 * (1 + STROBE_CLKS + RECOV_CLKS) + 66 + 1;
`else
  localparam int EXP_CLKS = 130 * (1 + STROBE_CLKS + RECOV_CLKS) + 66 + 1;
`endif

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        busak_n = 1'b1;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready, busrq_n, io_nIORQ, io_nWR, io_nRD, busy, done, err;
  logic [15:0] io_addr;
  logic [7:0]  io_dout, io_din;

  int n_cmp = 0;
  int n_fail = 0;

  // byte source
  int         src_ptr = 0;
  int         stall_clks = 0;
  int         stall_at = -1;
  logic       src_en = 1'b0;
  logic       src_clr = 1'b1;
  logic [7:0] mode_byte = 8'h01;

  // monitor / responder state
  int          wr_cnt = 0, done_cnt = 0, proto_err = 0, stall_seen = 0, rd_seen = 0;
  int          lowlen = 0, gap = 0;
  logic        prev_io = 1'b0, seen_strobe = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [7:0]  prev_dout = 8'h0;
  logic [15:0] log_addr [0:255];
  logic [7:0]  log_data [0:255];
  logic [7:0]  palette  [0:63];
  logic [7:0]  rsel = 8'h00;
  logic        ulap_ena = 1'b0, ulap_mono = 1'b0, corrupt = 1'b0;
  logic        err_snap = 1'b0;

  always #5 clk_sys = ~clk_sys;

  assign s_valid = src_en && (src_ptr <= 64) && !((src_ptr == stall_at) && (stall_clks < 20));
  assign s_data  = (src_ptr < 64) ? 8'(src_ptr) : mode_byte;
  assign io_din  = (corrupt && rsel == 8'd7) ? 8'hFF : palette[rsel[5:0]];

  always @(posedge clk_sys) begin
    if (src_clr) begin
      src_ptr    <= 0;
      stall_clks <= 0;
    end else begin
      if (s_valid && s_ready) src_ptr <= src_ptr + 1;
      if (s_ready && !s_valid && src_ptr == stall_at && stall_clks < 20) stall_clks <= stall_clks + 1;
    end
  end

  ulap_loader #(
    .STROBE_CLKS (STROBE_CLKS),
    .RECOV_CLKS  (RECOV_CLKS)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .busrq_n  (busrq_n),
    .busak_n  (busak_n),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_nIORQ (io_nIORQ),
    .io_nWR   (io_nWR),
    .io_nRD   (io_nRD),
    .io_din   (io_din),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Bus observer and ULAplus register model, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (!io_nRD) rd_seen++;
    if (reset) begin
      prev_io = 1'b0;
      lowlen  = 0;
    end else begin
      if (!io_nWR && !io_nRD) proto_err++;
      if ((!io_nWR || !io_nRD) && io_nIORQ) proto_err++;
      if (!io_nIORQ && io_nWR && io_nRD) proto_err++;
      if (done && busy) proto_err++;
      if (!io_nIORQ && !prev_io) begin
        if (io_addr !== prev_addr || io_dout !== prev_dout) proto_err++;
        if (seen_strobe && gap < RECOV_CLKS + 1) proto_err++;
        lowlen = 1;
        if (!io_nWR) begin
          if (wr_cnt < 256) begin
            log_addr[wr_cnt] = io_addr;
            log_data[wr_cnt] = io_dout;
          end
          wr_cnt++;
          if (io_addr == 16'hBF3B) rsel = io_dout;
          else if (io_addr == 16'hFF3B) begin
            if (rsel[6]) begin
              ulap_ena  = io_dout[0];
              ulap_mono = io_dout[1];
            end else palette[rsel[5:0]] = io_dout;
          end
        end
      end else if (!io_nIORQ) begin
        if (io_addr !== prev_addr || io_dout !== prev_dout) proto_err++;
        lowlen++;
      end else if (prev_io) begin
        if (lowlen != STROBE_CLKS) proto_err++;
        if (io_addr !== prev_addr || io_dout !== prev_dout) proto_err++;
        gap = 1;
        seen_strobe = 1'b1;
      end else gap++;
      if (src_ptr == stall_at && s_ready && !s_valid) begin
        stall_seen++;
        if (io_nIORQ !== 1'b1 || io_nWR !== 1'b1 || busrq_n !== 1'b0 || busy !== 1'b1) proto_err++;
      end
      prev_io   = !io_nIORQ;
      prev_addr = io_addr;
      prev_dout = io_dout;
    end
  end

  function automatic logic [15:0] exp_addr(input int k);
    return (k == 128 || (k < 128 && k % 2 == 0)) ? 16'hBF3B : 16'hFF3B;
  endfunction

  function automatic logic [7:0] exp_data(input int k, input logic [7:0] mode);
    if (k < 128) return 8'(k / 2);
    return (k == 128) ? 8'h40 : {6'b000000, mode[1:0]};
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic prep_source(input logic [7:0] mode, input int stall);
    mode_byte = mode;
    stall_at  = stall;
    src_clr   = 1'b1;
    src_en    = 1'b1;
    tick();
    src_clr     = 1'b0;
    wr_cnt      = 0;
    done_cnt    = 0;
    proto_err   = 0;
    stall_seen  = 0;
    seen_strobe = 1'b0;
  endtask

  // Full load: start, grant 5 clks after the request, optional start poke.
  task automatic run_load(input logic [7:0] mode, input int stall, input int poke_at,
                          output int clks, output bit tmo);
    int  n;
    bit  poked;
    prep_source(mode, stall);
    start = 1'b1;
    tick();
    start    = 1'b0;
    err_snap = err;
    tmo = 1'b0;
    n   = 0;
    while (busrq_n && n < 10) begin
      tick();
      n++;
    end
    if (busrq_n) tmo = 1'b1;
    repeat (5) tick();
    busak_n = 1'b0;
    clks  = 0;
    poked = 1'b0;
    while (done_cnt == 0 && clks < 6000) begin
      tick();
      clks++;
      if (!poked && poke_at >= 0 && wr_cnt == poke_at) begin
        start   = 1'b1;
        busak_n = 1'b1;
        poked   = 1'b1;
        tick();
        clks++;
        start = 1'b0;
      end
    end
    if (done_cnt == 0) tmo = 1'b1;
    repeat (6) tick();
    busak_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, err, busrq_n, io_nIORQ, io_nWR, io_nRD, s_ready} !== 8'b0001_1110) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00011110", {busy, done, err, busrq_n, io_nIORQ, io_nWR, io_nRD, s_ready});
    end
    n_cmp++;
    if (io_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", io_addr); end
    n_cmp++;
    if (io_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", io_dout); end
  endtask

  task automatic test_full_load();
    int clks, bad;
    bit tmo;
    run_load(8'h01, -1, -1, clks, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL full_timeout: got 1 want 0"); end
    n_cmp++;
    if (wr_cnt != 130) begin n_fail++; $display("FAIL full_wr_cnt: got %0d want 130", wr_cnt); end
    for (int k = 0; k < 130; k++) begin
      n_cmp++;
      if (log_addr[k] !== exp_addr(k) || log_data[k] !== exp_data(k, 8'h01)) begin
        n_fail++;
        $display("FAIL full_seq[%0d]: got %h:%h want %h:%h", k, log_addr[k], log_data[k], exp_addr(k), exp_data(k, 8'h01));
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (palette[i] !== 8'(i)) bad++;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL full_palette: got %0d bad entries want 0", bad); end
    n_cmp++;
    if ({ulap_ena, ulap_mono} !== 2'b10) begin n_fail++; $display("FAIL full_mode: got ena/mono %b want 10", {ulap_ena, ulap_mono}); end
    n_cmp++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL full_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++;
    if (clks != EXP_CLKS) begin n_fail++; $display("FAIL full_latency: got %0d want %0d", clks, EXP_CLKS); end
    n_cmp++;
    if ({busrq_n, busy, err, s_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL full_after: got busrq_n/busy/err/s_ready %b want 1000", {busrq_n, busy, err, s_ready});
    end
    n_cmp++;
    if (io_addr !== 16'h0000) begin n_fail++; $display("FAIL full_idle_addr: got %h want 0000", io_addr); end
    n_cmp++;
    if (proto_err != 0) begin n_fail++; $display("FAIL full_protocol: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_stall();
    int clks;
    bit tmo;
    run_load(8'h02, 10, -1, clks, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL stall_timeout: got 1 want 0"); end
    n_cmp++;
    if (stall_seen != 20) begin n_fail++; $display("FAIL stall_clks: got %0d want 20", stall_seen); end
    n_cmp++;
    if (wr_cnt != 130) begin n_fail++; $display("FAIL stall_wr_cnt: got %0d want 130", wr_cnt); end
    for (int k = 0; k < 130; k++) begin
      n_cmp++;
      if (log_addr[k] !== exp_addr(k) || log_data[k] !== exp_data(k, 8'h02)) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: got %h:%h want %h:%h", k, log_addr[k], log_data[k], exp_addr(k), exp_data(k, 8'h02));
      end
    end
    n_cmp++;
    if ({ulap_ena, ulap_mono} !== 2'b01) begin n_fail++; $display("FAIL stall_mode: got ena/mono %b want 01", {ulap_ena, ulap_mono}); end
    n_cmp++;
    if (proto_err != 0) begin n_fail++; $display("FAIL stall_protocol: got %0d violations want 0", proto_err); end
  endtask

  task automatic test_reset_mid_strobe();
    int  n, clks, bad;
    bit  tmo;
    prep_source(8'h01, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    busak_n = 1'b0;
    n = 0;
    while (!(wr_cnt == 64 && !io_nWR) && n < 3000) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!(wr_cnt == 64 && !io_nWR)) begin n_fail++; $display("FAIL midrst_reach: got wr_cnt %0d want 64 with strobe low", wr_cnt); end
    n_cmp++;
    if (log_addr[63] !== 16'hFF3B || log_data[63] !== 8'd31) begin
      n_fail++;
      $display("FAIL midrst_target: got %h:%h want ff3b:1f", log_addr[63], log_data[63]);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({io_nIORQ, io_nWR, io_nRD, busrq_n, busy, done, s_ready} !== 7'b1111000) begin
      n_fail++;
      $display("FAIL midrst_ctrl: got %b want 1111000", {io_nIORQ, io_nWR, io_nRD, busrq_n, busy, done, s_ready});
    end
    n_cmp++;
    if (io_addr !== 16'h0000 || io_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_bus: got %h:%h want 0000:00", io_addr, io_dout);
    end
    reset   = 1'b0;
    busak_n = 1'b1;
    for (int i = 0; i < 64; i++) palette[i] = 8'hEE;
    tick();
    run_load(8'h03, -1, -1, clks, tmo);
    n_cmp++;
    if (tmo || wr_cnt != 130) begin n_fail++; $display("FAIL midrst_reload: got tmo %0d wr_cnt %0d want 0 130", tmo, wr_cnt); end
    for (int k = 0; k < 130; k++) begin
      n_cmp++;
      if (log_addr[k] !== exp_addr(k) || log_data[k] !== exp_data(k, 8'h03)) begin
        n_fail++;
        $display("FAIL midrst_seq[%0d]: got %h:%h want %h:%h", k, log_addr[k], log_data[k], exp_addr(k), exp_data(k, 8'h03));
      end
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (palette[i] !== 8'(i)) bad++;
    n_cmp++;
    if (bad != 0 || {ulap_ena, ulap_mono} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_model: got %0d bad, ena/mono %b want 0, 11", bad, {ulap_ena, ulap_mono});
    end
  endtask

  task automatic test_start_ignored();
    int clks;
    bit tmo;
    run_load(8'h01, -1, 41, clks, tmo);
    n_cmp++;
    if (tmo) begin n_fail++; $display("FAIL ign_timeout: got 1 want 0"); end
    n_cmp++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++;
    if (wr_cnt != 130) begin n_fail++; $display("FAIL ign_wr_cnt: got %0d want 130", wr_cnt); end
    for (int k = 0; k < 130; k++) begin
      n_cmp++;
      if (log_addr[k] !== exp_addr(k) || log_data[k] !== exp_data(k, 8'h01)) begin
        n_fail++;
        $display("FAIL ign_seq[%0d]: got %h:%h want %h:%h", k, log_addr[k], log_data[k], exp_addr(k), exp_data(k, 8'h01));
      end
    end
    n_cmp++;
    if (busy !== 1'b0 || proto_err != 0) begin
      n_fail++;
      $display("FAIL ign_after: got busy %b violations %0d want 0 0", busy, proto_err);
    end
  endtask

`ifdef ULAP_LOADER_READBACK_EN
  task automatic test_readback();
    int clks;
    bit tmo;
    corrupt = 1'b1;
    run_load(8'h01, -1, -1, clks, tmo);
    n_cmp++;
    if (tmo || err !== 1'b1) begin n_fail++; $display("FAIL rb_err_set: got tmo %0d err %b want 0 1", tmo, err); end
    corrupt = 1'b0;
    run_load(8'h01, -1, -1, clks, tmo);
    n_cmp++;
    if (err_snap !== 1'b0) begin n_fail++; $display("FAIL rb_err_clear: got %b want 0", err_snap); end
    n_cmp++;
    if (tmo || err !== 1'b0) begin n_fail++; $display("FAIL rb_err_clean: got tmo %0d err %b want 0 0", tmo, err); end
  endtask
`else
  task automatic test_no_readback();
    n_cmp++;
    if (rd_seen != 0) begin n_fail++; $display("FAIL nrd_low: got %0d clks want 0", rd_seen); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL no_rb_err: got %b want 0", err); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_reset_mid_strobe();
    test_start_ignored();
`ifdef ULAP_LOADER_READBACK_EN
    test_readback();
`else
    test_no_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ulap_loader.md
ULAP_LOADER -- requirements
Module: ulap_loader

Interface
REQ-001 SHALL have parameter STROBE_CLKS, default 3, clk_sys cycles nIORQ/nWR (or nRD) held low per IO cycle (legal 2..15).
REQ-002 SHALL have parameter RECOV_CLKS, default 2, clk_sys cycles strobes high after each IO cycle (legal 1..15).
REQ-003 SHALL have ports, clock and reset first:
clk_sys  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high.
start  in  1  one-clk pulse; begins a palette load.
s_data  in  8  palette/mode byte stream.
s_valid  in  1  s_data valid.
s_ready  out  1  byte accepted when s_valid & s_ready.
busrq_n  out  1  bus request to CPU, active-low.
busak_n  in  1  bus grant from CPU, active-low.
io_addr  out  16  IO address driven while granted.
io_dout  out  8  IO write data.
io_nIORQ  out  1  IO request strobe, active-low.
io_nWR  out  1  write strobe, active-low.
io_nRD  out  1  read strobe, active-low (readback only).
io_din  in  8  IO read data (readback only).
busy  out  1  high from accepted start until done.
done  out  1  one-clk pulse at load completion.
err  out  1  sticky readback mismatch flag, cleared at start.

Function
REQ-004 SHALL, on start while idle, drive busrq_n=0 and wait (no timeout) until busak_n=0 sampled; start while busy SHALL be ignored.
REQ-005 SHALL, for idx=0..63 in order: fetch one byte, write port 16'hBF3B data {2'b00,idx}, write port 16'hFF3B the fetched byte.
REQ-006 SHALL then fetch one mode byte, write 16'hBF3B data 8'h40, write 16'hFF3B data {6'b0, mode[1:0]}.
REQ-007 SHALL then drive busrq_n=1, pulse done one clk, drop busy the same clk, return to IDLE.
REQ-008 SHALL assert s_ready only in FETCH state; with s_valid low the FSM SHALL stall in FETCH, bus held, strobes high.
REQ-009 Each IO cycle SHALL be: SETUP 1 clk (addr/data valid, strobes high), STROBE STROBE_CLKS clks (io_nIORQ=0 and io_nWR=0 or io_nRD=0), RECOV RECOV_CLKS clks (strobes high, addr/data held).
REQ-010 io_addr/io_dout SHALL be stable from SETUP through RECOV; strobes SHALL never be low outside STROBE; io_nWR and io_nRD SHALL never be low together.
REQ-011 FSM states: IDLE, BUSREQ, FETCH, WR_SEL, WR_DATA, RD_CHK (readback only), FETCH_MODE, WR_GRP, WR_MODE, FINISH.
REQ-012 idx SHALL be a 6-bit counter; wrap from 63 SHALL route to FETCH_MODE, never to entry 0.
REQ-013 Total per full load without readback, no stalls, immediate grant: 130 IO cycles x (1+STROBE_CLKS+RECOV_CLKS) clks plus 66 fetch clks.
REQ-014 busak_n deasserting mid-load SHALL not abort; outputs continue (bus arbitration is external).
REQ-015 In IDLE: io_addr=0, io_dout=0, all strobes 1, busrq_n=1, s_ready=0.

Reset
REQ-016 reset SHALL, in any state including mid-strobe, in the same clk force IDLE, busrq_n=1, strobes 1, busy=0, done=0, err=0, s_ready=0, io_addr=0, io_dout=0, idx=0.

Configuration
REQ-017 Macro ULAP_LOADER_READBACK_EN defined: after each WR_DATA, SHALL run one read cycle of 16'hFF3B (io_nIORQ=0, io_nRD=0), sample io_din on last STROBE clk, set err if not equal to written byte; mode write not checked.
REQ-018 Macro undefined: no RD_CHK state, io_nRD tied 1, io_din unused, err tied 0.

Structure
REQ-019 Shared package ulap_pkg SHALL hold: ULAP_SEL_PORT=16'hBF3B, ULAP_DATA_PORT=16'hFF3B, ULAP_GRP_MODE=8'h40, palette size 64, state enum type.
REQ-020 Sub-module ulap_io_cycle SHALL sequence one SETUP/STROBE/RECOV cycle (inputs go, addr, data, is_read; outputs strobes, rdata, ack pulse on final RECOV clk).

Verification
REQ-021 start, grant after 5 clks, stream bytes 0..63 then 8'h01 always valid -> 130 writes in order BF3B:00,FF3B:00,...,BF3B:3F,FF3B:3F,BF3B:40,FF3B:01; done once; busrq_n=1 after.
REQ-022 Responder model (edge-detect of ~nIORQ&~nWR) -> palette[i]=i, ulap_ena=1, ulap_mono=0; no missed or double writes.
REQ-023 s_valid low 20 clks before idx 10 -> s_ready high throughout stall, strobes high, bus held, sequence resumes intact.
REQ-024 reset asserted during STROBE of idx 31 data write -> next clk strobes 1, busrq_n=1, busy=0; new start reloads from idx 0.
REQ-025 READBACK_EN, responder returns 8'hFF for idx 7 -> err=1 sticky to done, cleared on next start; undefined -> io_nRD always 1.
REQ-026 start pulsed again while busy at idx 20 -> ignored, single done.
